// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types, defaults and rotate helper for the FFT sequencer
package fft_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_N_2   = 5;

    // Widest address the rotate helper supports; callers truncate to their own N_2.
    localparam int ROT_MAX   = 32;
    localparam int ROT_IDX_W = $clog2(ROT_MAX);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } fft_state_t;

    // Rotate the low 'bits' bits of value left by 'amount', wrapping within 'bits'.
    function automatic logic [ROT_MAX-1:0] rotl(
        input logic [ROT_MAX-1:0] value,
        input int unsigned        amount,
        input int unsigned        bits
    );
        logic [ROT_MAX-1:0]   result;
        logic [ROT_IDX_W-1:0] pos;
        int unsigned          dst;
        result = '0;
        for (int j = 0; j < ROT_MAX; j++) begin
            if (j < int'(bits)) begin
                dst         = (int'(j) + amount) % bits;
                pos         = dst[ROT_IDX_W-1:0];
                result[pos] = value[j[ROT_IDX_W-1:0]];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_agu.sv
// rtl/fft_agu.sv - combinational butterfly address and twiddle index generator
module fft_agu
    import fft_pkg::*;
#(
    parameter int N_2     = DEFAULT_N_2,
    parameter int LEVEL_W = $clog2(N_2)
) (
    input  logic [LEVEL_W-1:0] level,
    input  logic [N_2-2:0]     i,
    output logic [N_2-1:0]     adra,
    output logic [N_2-1:0]     adrb,
    output logic [N_2-2:0]     twiddleadr
);

    always_comb begin
        adra = N_2'(rotl(ROT_MAX'({i, 1'b0}), 32'(level), N_2));
        adrb = N_2'(rotl(ROT_MAX'({i, 1'b1}), 32'(level), N_2));
        // Keep only the top 'level' bits of i; level 0 masks everything away.
        twiddleadr = i & (N_2-1)'(~((ROT_MAX'(1) << (ROT_MAX'(N_2 - 1) - ROT_MAX'(level)))
                                    - ROT_MAX'(1)));
    end

endmodule

// File: rtl/fft_control.sv
// rtl/fft_control.sv - in-place radix-2 DIT FFT butterfly sequencer
module fft_control
    import fft_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH,
    parameter int N_2   = DEFAULT_N_2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           we,
    output logic [N_2-1:0] adra,
    output logic [N_2-1:0] adrb,
    output logic [N_2-2:0] twiddleadr
);

    localparam int LEVEL_W = $clog2(N_2);
    localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(N_2 - 1);
    localparam logic [N_2-2:0]     I_LAST     = '1;

    if (width < 1) begin : g_width_check
        $error("fft_control: width must be positive");
    end

    fft_state_t         state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [N_2-2:0]     i_q, i_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            level_q <= '0;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            i_q     <= i_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        i_d     = i_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    level_d = '0;
                    i_d     = '0;
                end
            end
            READ: state_d = WRITE;
            WRITE: begin
                if (i_q != I_LAST) begin
                    i_d     = i_q + 1'b1;
                    state_d = READ;
                end else if (level_q != LEVEL_LAST) begin
                    i_d     = '0;
                    level_d = level_q + 1'b1;
                    state_d = READ;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                level_d = '0;
                i_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == READ) || (state_q == WRITE);
    assign we   = (state_q == WRITE);
    assign done = (state_q == DONE);

    fft_agu #(
        .N_2     (N_2),
        .LEVEL_W (LEVEL_W)
    ) u_agu (
        .level      (level_q),
        .i          (i_q),
        .adra       (adra),
        .adrb       (adrb),
        .twiddleadr (twiddleadr)
    );

endmodule

// File: tb/tb_fft_control.sv
// tb/tb_fft_control.sv - directed self-checking bench for fft_control
module tb_fft_control;

    logic       clk;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic       we;
    logic [4:0] adra;
    logic [4:0] adrb;
    logic [3:0] twiddleadr;

    int checks;
    int errors;

    logic [4:0] log_adra [0:255];
    logic [4:0] log_adrb [0:255];
    logic [3:0] log_tw   [0:255];
    logic       log_we   [0:255];
    logic       log_busy [0:255];
    int         write_hits [0:31];
    int         first_done;
    int         done_count;
    int         we_count;
    int         busy_after_done;

    fft_control #(
        .width (16),
        .N_2   (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .we         (we),
        .adra       (adra),
        .adrb       (adrb),
        .twiddleadr (twiddleadr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulse start (sampled at edge k), then log cycles k+1..k+n_cycles.
    task automatic run_transform(input int n_cycles, input int pulse_at);
        for (int a = 0; a < 32; a++) write_hits[a] = 0;
        first_done      = 0;
        done_count      = 0;
        we_count        = 0;
        busy_after_done = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= n_cycles; n++) begin
            log_adra[n] = adra;
            log_adrb[n] = adrb;
            log_tw[n]   = twiddleadr;
            log_we[n]   = we;
            log_busy[n] = busy;
            if (done === 1'b1) begin
                done_count++;
                if (first_done == 0) first_done = n;
            end
            if (first_done != 0 && n > first_done && busy === 1'b1) busy_after_done++;
            if (we === 1'b1) begin
                we_count++;
                write_hits[adra]++;
                write_hits[adrb]++;
            end
            start = (n == pulse_at);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        checks++;
        if ({busy, done, we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold busy/done/we got %b want 000", {busy, done, we});
        end
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if ({busy, done, we, adra, adrb, twiddleadr} !== {3'b000, 5'd0, 5'd1, 4'd0}) begin
                errors++;
                $display("FAIL idle_outputs cycle %0d got b%b d%b w%b a%0d b%0d t%0d want 0 0 0 0 1 0",
                         c, busy, done, we, adra, adrb, twiddleadr);
            end
        end
    endtask

    task automatic check_bfly(input string name, input int n, input logic [4:0] ea,
                              input logic [4:0] eb, input logic [3:0] et, input logic ew);
        checks++;
        if ({log_adra[n], log_adrb[n], log_tw[n], log_we[n], log_busy[n]} !== {ea, eb, et, ew, 1'b1}) begin
            errors++;
            $display("FAIL %s cycle %0d got a%0d b%0d t%0d we%b busy%b want a%0d b%0d t%0d we%b busy1",
                     name, n, log_adra[n], log_adrb[n], log_tw[n], log_we[n], log_busy[n],
                     ea, eb, et, ew);
        end
    endtask

    task automatic test_butterflies;
        run_transform(200, 0);
        check_bfly("first_read",       1,   5'd0,  5'd1,  4'd0,  1'b0);
        check_bfly("first_write",      2,   5'd0,  5'd1,  4'd0,  1'b1);
        check_bfly("l0_i15",           31,  5'd30, 5'd31, 4'd0,  1'b0);
        check_bfly("l1_i1",            35,  5'd4,  5'd6,  4'd0,  1'b0);
        check_bfly("l2_i5",            75,  5'd9,  5'd13, 4'd4,  1'b0);
        check_bfly("l4_i3",            135, 5'd3,  5'd19, 4'd3,  1'b0);
        check_bfly("l4_i15_write",     160, 5'd15, 5'd31, 4'd15, 1'b1);
    endtask

    task automatic test_full_run;
        int bad_hits;
        checks++;
        if (first_done !== 161) begin
            errors++;
            $display("FAIL done_latency got %0d want 161", first_done);
        end
        checks++;
        if (done_count !== 1) begin
            errors++;
            $display("FAIL done_width got %0d want 1", done_count);
        end
        checks++;
        if (we_count !== 80) begin
            errors++;
            $display("FAIL we_cycles got %0d want 80", we_count);
        end
        bad_hits = 0;
        for (int a = 0; a < 32; a++) if (write_hits[a] != 5) bad_hits++;
        checks++;
        if (bad_hits !== 0) begin
            errors++;
            $display("FAIL write_coverage addresses_not_5 got %0d want 0 (addr0 hits %0d)",
                     bad_hits, write_hits[0]);
        end
        checks++;
        if ({log_busy[160], log_busy[161]} !== 2'b10) begin
            errors++;
            $display("FAIL busy_fall got %b want 10", {log_busy[160], log_busy[161]});
        end
        checks++;
        if (busy_after_done !== 0) begin
            errors++;
            $display("FAIL busy_after_done got %0d want 0", busy_after_done);
        end
    endtask

    task automatic test_ignored_start;
        run_transform(200, 50);
        checks++;
        if (first_done !== 161 || done_count !== 1) begin
            errors++;
            $display("FAIL ignored_start_done got at %0d count %0d want 161 1", first_done, done_count);
        end
        checks++;
        if (we_count !== 80 || busy_after_done !== 0) begin
            errors++;
            $display("FAIL ignored_start_rerun got we %0d busy_after %0d want 80 0",
                     we_count, busy_after_done);
        end
    endtask

    task automatic test_reset_mid;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 70; n++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy got %b want 1", busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, we, done, adra, adrb, twiddleadr} !== {3'b000, 5'd0, 5'd1, 4'd0}) begin
            errors++;
            $display("FAIL mid_reset got b%b w%b d%b a%0d b%0d t%0d want 0 0 0 0 1 0",
                     busy, we, done, adra, adrb, twiddleadr);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_stays_idle got %b want 0", busy);
        end
        run_transform(170, 0);
        check_bfly("restart_first_read", 1, 5'd0, 5'd1, 4'd0, 1'b0);
        checks++;
        if (first_done !== 161 || we_count !== 80) begin
            errors++;
            $display("FAIL restart_run got done %0d we %0d want 161 80", first_done, we_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        @(negedge clk);
        test_reset();
        test_butterflies();
        test_full_run();
        test_ignored_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
